// File: rtl/paula_audio_mixer.sv
// paula_audio_mixer: four-channel Paula volume mixer with one time-shared multiplier, one 8-phase frame per output word
module paula_audio_mixer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic [7:0]  sample0,
  input  logic [7:0]  sample1,
  input  logic [7:0]  sample2,
  input  logic [7:0]  sample3,
  input  logic [6:0]  vol0,
  input  logic [6:0]  vol1,
  input  logic [6:0]  vol2,
  input  logic [6:0]  vol3,
  input  logic [3:0]  chan_en,
  output logic [14:0] ldatasum,
  output logic [14:0] rdatasum,
  output logic        mix_valid
);
  logic [2:0]       ph;
  logic [3:0][7:0]  snap_s;
  logic [3:0][6:0]  snap_v;
  logic [3:0]       snap_en;
  logic [13:0]      prod;
  logic [14:0]      acc_l;
  logic [14:0]      acc_r;
  logic [1:0]       mi;
  logic [13:0]      mul;
  logic [14:0]      prod_x;
  logic             to_l;
  function automatic logic [6:0] eff_vol(input logic [6:0] v);
    return v[6] ? 7'd64 : {1'b0, v[5:0]};
  endfunction
  // The 14-bit product of the sign-extended sample and zero-extended volume is exact, since the result fits in 14 bits
  always_comb begin
    mi     = ph[1:0] - 2'd1;
    mul    = snap_en[mi] ? {{6{snap_s[mi][7]}}, snap_s[mi]} * {7'b0, snap_v[mi]} : 14'd0;
    prod_x = {prod[13], prod};
    to_l   = (ph == 3'd2) || (ph == 3'd5);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph        <= 3'd0;
      snap_s    <= '0;
      snap_v    <= '0;
      snap_en   <= 4'd0;
      prod      <= 14'd0;
      acc_l     <= 15'd0;
      acc_r     <= 15'd0;
      ldatasum  <= 15'd0;
      rdatasum  <= 15'd0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= clk7_en && (ph == 3'd6);
      if (clk7_en) begin
        ph <= ph + 3'd1;
        if (ph == 3'd0) begin
          snap_s  <= {sample3, sample2, sample1, sample0};
          snap_v  <= {eff_vol(vol3), eff_vol(vol2), eff_vol(vol1), eff_vol(vol0)};
          snap_en <= chan_en;
          acc_l   <= 15'd0;
          acc_r   <= 15'd0;
        end
        if (ph >= 3'd1 && ph <= 3'd4)
          prod <= mul;
        // prod lags the channel index by one phase: ph2..ph5 carry ch0, ch1, ch2, ch3
        if (ph >= 3'd2 && ph <= 3'd5) begin
          if (to_l)
            acc_l <= acc_l + prod_x;
          else
            acc_r <= acc_r + prod_x;
        end
        if (ph == 3'd6) begin
          ldatasum <= acc_l;
          rdatasum <= acc_r;
        end
      end
    end
  end
endmodule

// File: tb/tb_paula_audio_mixer.sv
// tb_paula_audio_mixer: directed checks of reset, mixing arithmetic, snapshot isolation, stall and abort
module tb_paula_audio_mixer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk7_en = 1'b0;
  logic [7:0]  s [4];
  logic [6:0]  v [4];
  logic [3:0]  chan_en = 4'hF;
  logic [14:0] ldatasum, rdatasum;
  logic        mix_valid;
  int          checks = 0;
  int          failures = 0;

  paula_audio_mixer dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en),
    .sample0(s[0]), .sample1(s[1]), .sample2(s[2]), .sample3(s[3]),
    .vol0(v[0]), .vol1(v[1]), .vol2(v[2]), .vol3(v[3]),
    .chan_en(chan_en), .ldatasum(ldatasum), .rdatasum(rdatasum), .mix_valid(mix_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input logic en);
    clk7_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic run7();
    for (int i = 0; i < 7; i++) step(1'b1);
  endtask

  task automatic set_all(input logic [7:0] sv, input logic [6:0] vv);
    for (int i = 0; i < 4; i++) begin
      s[i] = sv;
      v[i] = vv;
    end
  endtask

  task automatic test_reset();
    logic early;
    set_all(8'h11, 7'h01);
    chan_en = 4'hF;
    reset = 1'b1;
    step(1'b1);
    step(1'b1);
    checks++; if (ldatasum !== 15'd0) begin failures++; $display("FAIL reset_l: got %h exp 0", ldatasum); end
    checks++; if (rdatasum !== 15'd0) begin failures++; $display("FAIL reset_r: got %h exp 0", rdatasum); end
    checks++; if (mix_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", mix_valid); end
    reset = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      if (mix_valid !== 1'b0) early = 1'b1;
    end
    checks++; if (early) begin failures++; $display("FAIL reset_early_valid: got 1 exp 0"); end
    step(1'b1);
    checks++; if (mix_valid !== 1'b1) begin failures++; $display("FAIL reset_first_valid: got %b exp 1", mix_valid); end
    checks++; if (ldatasum !== 15'd34) begin failures++; $display("FAIL reset_first_l: got %0d exp 34", ldatasum); end
    checks++; if (rdatasum !== 15'd34) begin failures++; $display("FAIL reset_first_r: got %0d exp 34", rdatasum); end
    step(1'b1);
  endtask

  task automatic test_full_pos();
    set_all(8'h7F, 7'h40);
    chan_en = 4'hF;
    run7();
    checks++; if (mix_valid !== 1'b1) begin failures++; $display("FAIL pos_valid: got %b exp 1", mix_valid); end
    checks++; if (ldatasum !== 15'h3F80) begin failures++; $display("FAIL pos_l: got %h exp 3f80", ldatasum); end
    checks++; if (rdatasum !== 15'h3F80) begin failures++; $display("FAIL pos_r: got %h exp 3f80", rdatasum); end
    step(1'b1);
    checks++; if (mix_valid !== 1'b0) begin failures++; $display("FAIL pos_valid_pulse: got %b exp 0", mix_valid); end
    checks++; if (ldatasum !== 15'h3F80) begin failures++; $display("FAIL pos_hold: got %h exp 3f80", ldatasum); end
  endtask

  task automatic test_full_neg();
    set_all(8'h80, 7'h7F);
    chan_en = 4'hF;
    run7();
    checks++; if (ldatasum !== 15'h4000) begin failures++; $display("FAIL neg_l: got %h exp 4000", ldatasum); end
    checks++; if (rdatasum !== 15'h4000) begin failures++; $display("FAIL neg_r: got %h exp 4000", rdatasum); end
    step(1'b1);
  endtask

  task automatic set_mixed();
    s[0] = 8'd100; v[0] = 7'd32;
    s[1] = 8'hFF;  v[1] = 7'd63;
    s[2] = 8'd0;   v[2] = 7'h40;
    s[3] = 8'hCE;  v[3] = 7'd10;
  endtask

  task automatic test_mixed();
    set_mixed();
    chan_en = 4'hF;
    run7();
    checks++; if (ldatasum !== 15'd2700) begin failures++; $display("FAIL mixed_l: got %h exp %h", ldatasum, 15'd2700); end
    checks++; if (rdatasum !== 15'h7FC1) begin failures++; $display("FAIL mixed_r: got %h exp 7fc1", rdatasum); end
    step(1'b1);
    chan_en = 4'b1110;
    run7();
    checks++; if (ldatasum !== 15'h7E0C) begin failures++; $display("FAIL masked_l: got %h exp 7e0c", ldatasum); end
    checks++; if (rdatasum !== 15'h7FC1) begin failures++; $display("FAIL masked_r: got %h exp 7fc1", rdatasum); end
    step(1'b1);
    chan_en = 4'hF;
  endtask

  task automatic test_snapshot();
    set_all(8'h7F, 7'h40);
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 4; i++) s[i] = 8'h01;
    for (int i = 0; i < 4; i++) step(1'b1);
    checks++; if (ldatasum !== 15'h3F80) begin failures++; $display("FAIL snap_old_l: got %h exp 3f80", ldatasum); end
    checks++; if (rdatasum !== 15'h3F80) begin failures++; $display("FAIL snap_old_r: got %h exp 3f80", rdatasum); end
    step(1'b1);
    run7();
    checks++; if (ldatasum !== 15'd128) begin failures++; $display("FAIL snap_new_l: got %0d exp 128", ldatasum); end
    checks++; if (rdatasum !== 15'd128) begin failures++; $display("FAIL snap_new_r: got %0d exp 128", rdatasum); end
    step(1'b1);
  endtask

  task automatic test_stall();
    logic bad;
    set_mixed();
    chan_en = 4'hF;
    for (int i = 0; i < 3; i++) step(1'b1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      if (mix_valid !== 1'b0 || ldatasum !== 15'd128) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL stall_hold: got l=%0d v=%b exp l=128 v=0", ldatasum, mix_valid); end
    for (int i = 0; i < 4; i++) step(1'b1);
    checks++; if (mix_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b exp 1", mix_valid); end
    checks++; if (ldatasum !== 15'd2700) begin failures++; $display("FAIL stall_l: got %h exp %h", ldatasum, 15'd2700); end
    checks++; if (rdatasum !== 15'h7FC1) begin failures++; $display("FAIL stall_r: got %h exp 7fc1", rdatasum); end
    step(1'b0);
    checks++; if (mix_valid !== 1'b0) begin failures++; $display("FAIL stall_valid_drop: got %b exp 0", mix_valid); end
    step(1'b1);
  endtask

  task automatic test_abort();
    logic early;
    set_all(8'h80, 7'h7F);
    for (int i = 0; i < 5; i++) step(1'b1);
    #2 reset = 1'b1;
    #1;
    checks++; if (ldatasum !== 15'd0) begin failures++; $display("FAIL abort_l: got %h exp 0", ldatasum); end
    checks++; if (rdatasum !== 15'd0) begin failures++; $display("FAIL abort_r: got %h exp 0", rdatasum); end
    checks++; if (mix_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b exp 0", mix_valid); end
    step(1'b1);
    reset = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      if (mix_valid !== 1'b0) early = 1'b1;
    end
    checks++; if (early) begin failures++; $display("FAIL abort_early_valid: got 1 exp 0"); end
    step(1'b1);
    checks++; if (mix_valid !== 1'b1) begin failures++; $display("FAIL abort_restart_valid: got %b exp 1", mix_valid); end
    checks++; if (ldatasum !== 15'h4000) begin failures++; $display("FAIL abort_restart_l: got %h exp 4000", ldatasum); end
    step(1'b1);
  endtask

  initial begin
    test_reset();
    test_full_pos();
    test_full_neg();
    test_mixed();
    test_snapshot();
    test_stall();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/paula_audio_mixer.md
# paula_audio_mixer

Time-multiplexed four-channel Paula volume mixer. It scales each channel's 8-bit signed sample by its 7-bit Paula volume using a single shared multiplier. Channels 0+3 are summed to left and channels 1+2 to right. It produces the 15-bit signed `ldatasum`/`rdatasum` words consumed directly by the stereo sigma-delta modulator, and sits between the four audio channel state machines and that modulator.

## Interface
Parameters:
- none; all widths fixed by the Paula audio format.

Ports:
- `clk` in 1: bus clock.
- `reset` in 1: asynchronous, active-high reset.
- `clk7_en` in 1: 7 MHz clock enable. All state advances only on `clk` edges where `clk7_en`=1.
- `sample0`..`sample3` in 8 each: channel samples, two's complement.
- `vol0`..`vol3` in 7 each: Paula volume. If bit 6 is set, the effective volume is 64 and bits 5:0 are ignored; otherwise the effective volume is bits 5:0 (0..63).
- `chan_en` in 4: per-channel enable. A disabled channel contributes 0.
- `ldatasum` out 15: left mix (ch0+ch3), two's complement, registered.
- `rdatasum` out 15: right mix (ch1+ch2), two's complement, registered.
- `mix_valid` out 1: one-`clk` pulse on the cycle `ldatasum`/`rdatasum` update.

## Operation
- Phase counter `ph` is 3 bits and runs 0..7. It increments on each `clk7_en` cycle and wraps from 7 to 0. One frame is 8 enabled cycles.
- Actions per enabled cycle, keyed on the current `ph`:
  - ph0: snapshot all four samples, the four effective volumes and `chan_en`. Clear `acc_l` and `acc_r` to 0.
  - ph1..ph4: `prod` <= snap_sample[ph-1] × snap_effvol[ph-1]. If snap_en[ph-1]=0, `prod` <= 0.
  - ph2..ph5: accumulate the `prod` registered in the previous phase. Channel 0 and channel 3 products go to `acc_l`; channel 1 and channel 2 products go to `acc_r`.
  - ph6: `ldatasum` <= `acc_l`, `rdatasum` <= `acc_r`, `mix_valid` <= 1.
  - ph7: idle.
- `mix_valid` is 0 on every other cycle, including `clk` cycles with `clk7_en`=0.
- Arithmetic:
  - The multiply is signed 8-bit × unsigned 7-bit (0..64) into a 14-bit signed `prod`. Range is −8192..+8128.
  - Accumulators are 15-bit signed. The sum of two products is bounded to −16384..+16256, so no saturation logic is needed and overflow is impossible.
- Snapshot isolation: input changes after the ph0 enabled cycle do not affect the current frame.
- States are the eight phases only; there are no other states and no handshake on the input side.

## Timing
- Reset, asynchronous: `ph`=0, snapshots=0, `prod`=0, `acc_l`=`acc_r`=0, `ldatasum`=0, `rdatasum`=0, `mix_valid`=0.
- After reset deasserts, the first enabled cycle is ph0.
- Latency: inputs sampled at enabled cycle N (ph0) appear on the outputs after enabled cycle N+6 (ph6). The `mix_valid` pulse coincides with that update.
- Output update rate is `clk7_en`/8. Outputs hold their value between updates.
- With `clk7_en`=0, all registers hold. A stall mid-frame freezes the frame and resumes it without corruption.
- Reset asserted mid-frame aborts the frame. Outputs return to 0 immediately, asynchronously.

## Test plan
- Reset: assert `reset` with arbitrary inputs → all outputs 0 and `mix_valid`=0. The first `mix_valid` occurs on the 7th enabled cycle after deassertion.
- Full scale positive: all samples 8'h7F, vols 7'h40, `chan_en`=4'hF → `ldatasum`=`rdatasum`=15'h3F80 (16256).
- Full scale negative: all samples 8'h80, vols 7'h7F (bit 6 forces 64) → `ldatasum`=`rdatasum`=15'h4000 (−16384).
- Mixed:
  - Inputs: ch0=100/vol 32, ch3=−50/vol 10, ch1=−1/vol 63, ch2=0/vol 64 → `ldatasum`=2700, `rdatasum`=−63.
  - Same inputs with `chan_en`=4'b1110 → `ldatasum`=−500.
- Snapshot: change all samples at ph3 → the current frame's output reflects the old values; the next frame reflects the new values.
- Stall and abort:
  - Drop `clk7_en` for 5 cycles at ph3 → results equal the unstalled frame, delayed by 5 cycles.
  - Assert `reset` at ph5 → outputs 0 immediately, and the next frame restarts at ph0.
